// File: rtl/fifo_rd_packer_if.sv
// fifo_rd_packer_if: FIFO read port, flush request and packed output stream.
interface fifo_rd_packer_if #(
  parameter int W_IN   = 8,
  parameter int NBYTES = 4
);
  logic [W_IN-1:0]             rdata;
  logic                        rrdy;
  logic                        rget;
  logic                        flush;
  logic [W_IN*NBYTES-1:0]      out_data;
  logic [$clog2(NBYTES+1)-1:0] out_bytes;
  logic                        out_valid;
  logic                        out_ready;
  modport master (
    output rdata, rrdy, flush, out_ready,
    input  rget, out_data, out_bytes, out_valid
  );
  modport slave (
    input  rdata, rrdy, flush, out_ready,
    output rget, out_data, out_bytes, out_valid
  );
endinterface

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: pops narrow FIFO words and packs NBYTES of them into one wide output word.
module fifo_rd_packer #(
  parameter int W_IN   = 8,
  parameter int NBYTES = 4
) (
  input logic            rclk,
  input logic            rrst_n,
  fifo_rd_packer_if.slave bus
);
  localparam int DW = W_IN * NBYTES;
  localparam int CW = $clog2(NBYTES);
  localparam int BW = $clog2(NBYTES + 1);
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);
  logic [DW-1:0] acc, acc_n;
  logic [CW-1:0] cnt;
  logic          flush_pend, free, pop, load;
  assign free = !bus.out_valid || bus.out_ready;
  // Stall only the final lane: earlier lanes can accumulate behind a held word.
  assign bus.rget = rrst_n && bus.rrdy && !(cnt == LAST && !free);
  assign pop = bus.rget;
  // A final-lane pop always loads; its full word also satisfies a coincident flush.
  assign load = (pop && cnt == LAST) || ((bus.flush || flush_pend) && free && (cnt != '0 || pop));
  always_comb begin
    acc_n = acc;
    for (int i = 0; i < NBYTES; i++)
      if (pop && cnt == CW'(i)) acc_n[i*W_IN +: W_IN] = bus.rdata;
  end
  always_ff @(posedge rclk or negedge rrst_n)
    if (!rrst_n) begin
      acc           <= '0;
      cnt           <= '0;
      flush_pend    <= 1'b0;
      bus.out_data  <= '0;
      bus.out_bytes <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      if (load) begin
        bus.out_data  <= acc_n;
        bus.out_bytes <= BW'(cnt) + BW'(pop);
        bus.out_valid <= 1'b1;
        acc           <= '0;
        cnt           <= '0;
      end else begin
        if (free) bus.out_valid <= 1'b0;
        if (pop) begin
          acc <= acc_n;
          cnt <= cnt + CW'(1);
        end
      end
      flush_pend <= (load || (cnt == '0 && !pop)) ? 1'b0 : (flush_pend || bus.flush);
    end
endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: directed vector table plus scoreboard-checked random traffic.
module tb_fifo_rd_packer;
  localparam int W = 8;
  localparam int N = 4;
  typedef logic [W*N-1:0] word_t;
  typedef struct {
    logic       rrdy;
    logic [7:0] data;
    logic       flush;
    logic       ready;
    logic       e_rget;
    logic       e_valid;
    word_t      e_data;
    logic [2:0] e_bytes;
  } vec_t;
  typedef struct {
    word_t d;
    int    b;
  } ent_t;

  logic rclk = 1'b0;
  logic rrst_n = 1'b1;
  always #5 rclk = ~rclk;

  fifo_rd_packer_if #(.W_IN(W), .NBYTES(N)) bus ();
  fifo_rd_packer #(.W_IN(W), .NBYTES(N)) dut (.rclk(rclk), .rrst_n(rrst_n), .bus(bus));

  int         checks = 0;
  int         errors = 0;
  logic [7:0] lanes[$];
  ent_t       sb[$];
  logic       m_valid = 1'b0;
  logic       m_pend = 1'b0;
  vec_t       tab[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rr, input logic [7:0] d, input logic fl, input logic rd,
                              input logic er, input logic ev, input word_t ed, input logic [2:0] eb);
    mk = '{rr, d, fl, rd, er, ev, ed, eb};
  endfunction

  task automatic drive(input logic rr, input logic [7:0] d, input logic fl, input logic rd);
    @(negedge rclk);
    bus.rrdy = rr;
    bus.rdata = d;
    bus.flush = fl;
    bus.out_ready = rd;
    #1;
  endtask

  // Check outputs against the model for the coming edge, then advance the model across it.
  task automatic step();
    logic  free, er;
    ent_t  e;
    word_t w;
    free = !m_valid || bus.out_ready;
    er = bus.rrdy && !(lanes.size() == N - 1 && !free);
    chk("rget", bus.rget, er);
    chk("rget_without_rrdy", bus.rget & ~bus.rrdy, 0);
    chk("out_valid", bus.out_valid, m_valid);
    if (m_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty got transfer want none");
      end else begin
        e = sb.pop_front();
        chk("out_data", bus.out_data, e.d);
        chk("out_bytes", bus.out_bytes, e.b);
      end
      m_valid = 1'b0;
    end
    if (er) lanes.push_back(bus.rdata);
    if (lanes.size() == N || ((bus.flush || m_pend) && free && lanes.size() > 0)) begin
      w = '0;
      foreach (lanes[i]) w[i*W +: W] = lanes[i];
      sb.push_back('{w, lanes.size()});
      lanes.delete();
      m_valid = 1'b1;
      m_pend = 1'b0;
    end else if (lanes.size() == 0) m_pend = 1'b0;
    else if (bus.flush) m_pend = 1'b1;
    @(posedge rclk);
  endtask

  task automatic model_clear();
    lanes.delete();
    sb.delete();
    m_valid = 1'b0;
    m_pend = 1'b0;
  endtask

  task automatic do_reset();
    rrst_n = 1'b0;
    bus.rrdy = 1'b1;
    bus.rdata = 8'hFF;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_rget", bus.rget, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_bytes", bus.out_bytes, 0);
    model_clear();
    repeat (2) @(posedge rclk);
    @(negedge rclk);
    rrst_n = 1'b1;
    bus.rrdy = 1'b0;
  endtask

  initial begin
    // basic pack
    tab.push_back(mk(1, 8'h11, 0, 1, 1, 0, 0, 0));
    tab.push_back(mk(1, 8'h22, 0, 1, 1, 0, 0, 0));
    tab.push_back(mk(1, 8'h33, 0, 1, 1, 0, 0, 0));
    tab.push_back(mk(1, 8'h44, 0, 1, 1, 0, 0, 0));
    tab.push_back(mk(0, 8'h00, 0, 1, 0, 1, 32'h44332211, 4));
    tab.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0));
    // backpressure
    tab.push_back(mk(1, 8'h11, 0, 0, 1, 0, 0, 0));
    tab.push_back(mk(1, 8'h22, 0, 0, 1, 0, 0, 0));
    tab.push_back(mk(1, 8'h33, 0, 0, 1, 0, 0, 0));
    tab.push_back(mk(1, 8'h44, 0, 0, 1, 0, 0, 0));
    tab.push_back(mk(1, 8'h55, 0, 0, 1, 1, 32'h44332211, 4));
    tab.push_back(mk(1, 8'h66, 0, 0, 1, 1, 32'h44332211, 4));
    tab.push_back(mk(1, 8'h77, 0, 0, 1, 1, 32'h44332211, 4));
    tab.push_back(mk(1, 8'h88, 0, 0, 0, 1, 32'h44332211, 4));
    tab.push_back(mk(1, 8'h88, 0, 0, 0, 1, 32'h44332211, 4));
    tab.push_back(mk(1, 8'h88, 0, 1, 1, 1, 32'h44332211, 4));
    tab.push_back(mk(0, 8'h00, 0, 1, 0, 1, 32'h88776655, 4));
    tab.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 0));
    // partial flush
    tab.push_back(mk(1, 8'hA1, 0, 1, 1, 0, 0, 0));
    tab.push_back(mk(1, 8'hB2, 0, 1, 1, 0, 0, 0));
    tab.push_back(mk(0, 8'h00, 1, 1, 0, 0, 0, 0));
    tab.push_back(mk(0, 8'h00, 0, 1, 0, 1, 32'h0000B2A1, 2));
    // flush with third pop
    tab.push_back(mk(1, 8'hC1, 0, 1, 1, 0, 0, 0));
    tab.push_back(mk(1, 8'hC2, 0, 1, 1, 0, 0, 0));
    tab.push_back(mk(1, 8'hC3, 1, 1, 1, 0, 0, 0));
    tab.push_back(mk(0, 8'h00, 0, 1, 0, 1, 32'h00C3C2C1, 3));
    // flush with nothing accumulated, then flush on the final lane
    tab.push_back(mk(0, 8'h00, 1, 1, 0, 0, 0, 0));
    tab.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 0));
    tab.push_back(mk(1, 8'hD1, 0, 1, 1, 0, 0, 0));
    tab.push_back(mk(1, 8'hD2, 0, 1, 1, 0, 0, 0));
    tab.push_back(mk(1, 8'hD3, 0, 1, 1, 0, 0, 0));
    tab.push_back(mk(1, 8'hD4, 1, 1, 1, 0, 0, 0));
    tab.push_back(mk(0, 8'h00, 0, 1, 0, 1, 32'hD4D3D2D1, 4));
    tab.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 0));

    #2;
    do_reset();
    foreach (tab[i]) begin
      drive(tab[i].rrdy, tab[i].data, tab[i].flush, tab[i].ready);
      chk($sformatf("row%0d_rget", i), bus.rget, tab[i].e_rget);
      chk($sformatf("row%0d_valid", i), bus.out_valid, tab[i].e_valid);
      if (tab[i].e_valid) begin
        chk($sformatf("row%0d_data", i), bus.out_data, tab[i].e_data);
        chk($sformatf("row%0d_bytes", i), bus.out_bytes, tab[i].e_bytes);
      end
      step();
    end

    // async reset after two pops discards the partial word
    drive(1, 8'hE1, 0, 1);
    step();
    drive(1, 8'hE2, 0, 1);
    step();
    #3;
    rrst_n = 1'b0;
    #1;
    chk("midrst_rget", bus.rget, 0);
    chk("midrst_valid", bus.out_valid, 0);
    model_clear();
    @(negedge rclk);
    rrst_n = 1'b1;
    bus.rrdy = 1'b0;
    drive(1, 8'hF1, 0, 1);
    step();
    drive(1, 8'hF2, 0, 1);
    step();
    drive(1, 8'hF3, 0, 1);
    step();
    drive(1, 8'hF4, 0, 1);
    step();
    drive(0, 8'h00, 0, 1);
    chk("midrst_word", bus.out_data, 32'hF4F3F2F1);
    chk("midrst_bytes", bus.out_bytes, 4);
    step();

    // random traffic
    for (int n = 0; n < 10000; n++) begin
      drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
      step();
    end
    repeat (4) begin
      drive(0, 8'h00, 1, 1);
      step();
    end
    chk("drain_left", sb.size() + lanes.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Read-side consumer for the 2-deep clock-domain-crossing FIFO. It sits in the read clock domain, pops narrow words from the FIFO read port (rdata/rrdy/rget) and packs `NBYTES` consecutive words into one wide word. The wide word is presented on a valid/ready output stream. A flush input emits a partially filled word so that trailing data is never stranded.

## Interface
- `W_IN`, default 8: width of one FIFO word (lane width).
- `NBYTES`, default 4: lanes per output word; legal range 2..16.
- `rclk`  in  1: read-domain clock; single clock for the block.
- `rrst_n`  in  1: reset, asynchronous assert, active-low.
- `rdata`  in  W_IN: FIFO read data; valid whenever `rrdy`=1.
- `rrdy`  in  1: FIFO has a word available.
- `rget`  out  1: pop strobe; a word is consumed on each rising `rclk` edge where `rget`=1.
- `flush`  in  1: single-cycle request to emit any partial word.
- `out_data`  out  W_IN*NBYTES: packed word; lane 0 = first word popped, in bits [W_IN-1:0].
- `out_bytes`  out  $clog2(NBYTES+1): number of valid lanes in `out_data`, 1..NBYTES.
- `out_valid`  out  1: output word available.
- `out_ready`  in  1: downstream accepts; a transfer occurs on an edge where `out_valid`=1 and `out_ready`=1.

## Operation
- State: accumulator `acc` (W_IN*NBYTES), lane counter `cnt` (0..NBYTES-1), output register (`out_data`, `out_bytes`, `out_valid`) and `flush_pend`.
- Output slot is free this cycle when `out_valid`=0, or when `out_valid`=1 and `out_ready`=1.
- `rget` = `rrdy` and not(`cnt`=NBYTES-1 and slot not free). It is combinational from `rrdy`, `cnt`, `out_valid` and `out_ready`. It is forced to 0 while `rrst_n`=0. It is never asserted when `rrdy`=0.
- Pop, non-final lane: `acc` lane[`cnt`] <= `rdata`; `cnt` <= `cnt`+1.
- Pop, final lane (`cnt`=NBYTES-1):
  - `out_data` <= `acc` with lane[NBYTES-1] = `rdata`.
  - `out_bytes` <= NBYTES; `out_valid` <= 1.
  - `cnt` <= 0; `acc` <= 0.
- Flush:
  - `flush`=1 sets `flush_pend`, unless it is serviced in the same cycle.
  - `flush_pend` or `flush` is serviced on the first edge where the slot is free and (`cnt`>0 or a non-final pop occurs on that edge).
  - The service loads `out_data` with `acc`, including any lane popped on that edge. Unused upper lanes are 0.
  - The service sets `out_bytes` to the lane count, `out_valid` to 1, clears `cnt`/`acc`, and clears `flush_pend`.
- Flush with `cnt`=0 and no pop on that edge: no-op, `flush_pend` cleared.
- Flush on the same edge as a final-lane pop: the full word (`out_bytes`=NBYTES) satisfies the flush; no extra word is emitted.
- Output handshake: if the slot is free and no new word is loaded, `out_valid` <= 0 on a transfer. Back-to-back words are allowed (transfer and load on the same edge).
- While `out_valid`=1 and `out_ready`=0, `out_data`/`out_bytes` are held stable.
- Lane counting wraps only via a final-lane pop or a flush service. `cnt` never reaches NBYTES.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_bytes`=0, `cnt`=0, `acc`=0, `flush_pend`=0, `rget`=0.
- Async reset mid-operation discards the partial word and the held output word immediately. Resume requires no extra idle cycle after release.
- Latency: the final-lane pop at edge k gives `out_valid`=1 from edge k (visible in the cycle after k).
- Throughput: one pop per cycle when `rrdy` stays high. With NBYTES=4, one output word per 4 cycles.
- Backpressure: with output held, `cnt` can advance to NBYTES-1 and then `rget` stays 0. At most one held output word plus NBYTES-1 accumulated lanes.
- No combinational path from `rdata` to any output.
- `rget` depends combinationally on `out_ready` and `rrdy`.

## Test plan
- Reset check, W_IN=8, NBYTES=4: while reset asserted, drive `rrdy`=1. Required: `rget`=0, `out_valid`=0, `out_data`=0.
- Basic pack: pop 0x11,0x22,0x33,0x44 on consecutive edges with `out_ready`=1. Required: `out_data`=0x44332211, `out_bytes`=4, `out_valid` for one cycle, starting the cycle after the 4th pop.
- Backpressure:
  - Hold `out_ready`=0 with 0x44332211 pending; present 0x55,0x66,0x77,0x88.
  - Required: three pops, then `rget`=0 with `rrdy`=1.
  - Raise `out_ready` for one cycle. Required: the first word transfers, 0x88 is popped on the same edge, and the next word is 0x88776655.
- Partial flush: pop 0xA1,0xB2, then pulse `flush`. Required: `out_data`=0x0000B2A1, `out_bytes`=2.
- Flush coincidences:
  - Flush on the same edge as the 3rd pop (0xC3). Required: `out_bytes`=3.
  - Flush with `cnt`=0. Required: no output.
  - Flush on a final-lane pop. Required: exactly one word, `out_bytes`=4.
- Reset mid-word and random traffic:
  - Assert `rrst_n` after 2 pops. Required: `cnt` cleared; the next 4 pops form a fresh word.
  - Random `rrdy`/`out_ready`/`flush` for 10k cycles, checked against a scoreboard. Required: byte order and counts exact, `rget` never high with `rrdy`=0.
